// File: rtl/pipe_mem.sv
// rtl/pipe_mem.sv - pipeline RAM with clear-on-reset sequencer, load port and registered read
module pipe_mem #(
  parameter int DW           = 16,
  parameter int AW           = 8,
  parameter int RD_MODE      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready_o,
  input  logic          a_en_i,
  input  logic          a_wen_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  output logic [DW-1:0] a_rdata_o,
  output logic          a_rvalid_o,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_data_i
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] mem_q [2**AW];

  logic          a_rd, a_wr, ld_acc;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // The counter wraps back to zero on the same edge that leaves CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      default: ready_d = 1'b1;
    endcase
  end

  always_comb begin
    a_rd       = ready_q & a_en_i & ~a_wen_i;
    a_wr       = ready_q & a_en_i & a_wen_i;
    ld_ready_o = ready_q & ~(a_en_i & a_wen_i);
    ld_acc     = ld_valid_i & ld_ready_o;
    we         = 1'b0;
    waddr      = a_addr_i;
    wdata      = a_wdata_i;
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
      end else if (a_wr) begin
        we = 1'b1;
      end else if (ld_acc) begin
        we    = 1'b1;
        waddr = ld_addr_i;
        wdata = ld_data_i;
      end
    end
  end

  // Write-first mode forwards the word being written in the same cycle.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (a_rd) begin
      rvalid_d = 1'b1;
      if (RD_MODE != 0 && we && waddr == a_addr_i) rdata_d = wdata;
      else                                         rdata_d = mem_q[a_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign ready_o    = ready_q;
  assign a_rdata_o  = rdata_q;
  assign a_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_pipe_mem.sv
// tb/tb_pipe_mem.sv - bench for pipe_mem: read-first, write-first and no-clear instances
module tb_pipe_mem;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        a_en, a_wen, ld_valid;
  logic [3:0]  a_addr, ld_addr;
  logic [15:0] a_wdata, ld_data;

  logic        ready0, ready1, ready2;
  logic        rvalid0, rvalid1, rvalid2;
  logic        ldrdy0, ldrdy1, ldrdy2;
  logic [15:0] rdata0, rdata1, rdata2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_mem #(.DW(16), .AW(4), .RD_MODE(0), .CLEAR_ON_RST(1)) u0 (
    .clk(clk), .rst(rst), .ready_o(ready0),
    .a_en_i(a_en), .a_wen_i(a_wen), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(rdata0), .a_rvalid_o(rvalid0),
    .ld_valid_i(ld_valid), .ld_ready_o(ldrdy0), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  pipe_mem #(.DW(16), .AW(4), .RD_MODE(1), .CLEAR_ON_RST(1)) u1 (
    .clk(clk), .rst(rst), .ready_o(ready1),
    .a_en_i(a_en), .a_wen_i(a_wen), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(rdata1), .a_rvalid_o(rvalid1),
    .ld_valid_i(ld_valid), .ld_ready_o(ldrdy1), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  pipe_mem #(.DW(16), .AW(4), .RD_MODE(0), .CLEAR_ON_RST(0)) u2 (
    .clk(clk), .rst(rst2), .ready_o(ready2),
    .a_en_i(a_en), .a_wen_i(a_wen), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(rdata2), .a_rvalid_o(rvalid2),
    .ld_valid_i(ld_valid), .ld_ready_o(ldrdy2), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  // Reference state: mA is shared by u0/u1 (identical write traffic), mB belongs to u2.
  logic [15:0] mA [16];
  logic [15:0] mB [16];
  int          clr_left = 16;
  logic        rdyA = 1'b0, rdyB = 1'b0, rvA = 1'b0, rvB = 1'b0;
  logic [15:0] rdA0 = '0, rdA1 = '0, rdB = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_en = 1'b0; a_wen = 1'b0; ld_valid = 1'b0;
  endtask

  // One clock: inputs are already driven; check combinational ld_ready, step model, check outputs.
  task automatic cyc();
    logic       wr;
    logic [3:0] ci;
    #1;
    wr = a_en & a_wen;
    chk("ld_ready0", ldrdy0, rdyA & ~wr);
    chk("ld_ready1", ldrdy1, rdyA & ~wr);
    chk("ld_ready2", ldrdy2, rdyB & ~wr);
    @(posedge clk);
    if (rst) begin
      rdyA = 1'b0; clr_left = 16; rvA = 1'b0; rdA0 = '0; rdA1 = '0;
    end else if (clr_left > 0) begin
      ci = 4'(16 - clr_left);
      mA[ci] = '0;
      clr_left--;
      rvA = 1'b0;
      if (clr_left == 0) rdyA = 1'b1;
    end else begin
      rvA = 1'b0;
      if (a_en && !a_wen) begin
        rvA  = 1'b1;
        rdA0 = mA[a_addr];
        rdA1 = (ld_valid && ld_addr == a_addr) ? ld_data : mA[a_addr];
      end
      if (wr) mA[a_addr] = a_wdata;
      else if (ld_valid) mA[ld_addr] = ld_data;
    end
    if (rst2) begin
      rdyB = 1'b0; rvB = 1'b0; rdB = '0;
    end else begin
      rvB = 1'b0;
      if (rdyB) begin
        if (a_en && !a_wen) begin
          rvB = 1'b1;
          rdB = mB[a_addr];
        end
        if (wr) mB[a_addr] = a_wdata;
        else if (ld_valid) mB[ld_addr] = ld_data;
      end
      rdyB = 1'b1;
    end
    #1;
    chk("ready0", ready0, rdyA);
    chk("ready1", ready1, rdyA);
    chk("ready2", ready2, rdyB);
    chk("rvalid0", rvalid0, rvA);
    chk("rvalid1", rvalid1, rvA);
    chk("rvalid2", rvalid2, rvB);
    chk("rdata0", rdata0, rdA0);
    chk("rdata1", rdata1, rdA1);
    chk("rdata2", rdata2, rdB);
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] ad);
    a_en = 1'b1; a_wen = 1'b0; a_addr = ad; ld_valid = 1'b0;
    cyc();
  endtask

  task automatic wr_a(input logic [3:0] ad, input logic [15:0] d);
    a_en = 1'b1; a_wen = 1'b1; a_addr = ad; a_wdata = d; ld_valid = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    idle(); a_addr = '0; a_wdata = '0; ld_addr = '0; ld_data = '0;
    @(posedge clk);
    @(negedge clk);
    cyc();
    chk("rst_ready0", ready0, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_ldready2", ldrdy2, 0);

    // Release both resets; fill u2 through the load port while u0/u1 clear.
    rst = 1'b0; rst2 = 1'b0;
    for (int k = 0; k < 17; k++) begin
      ld_valid = 1'b1; ld_addr = 4'(k); ld_data = 16'($urandom);
      cyc();
      if (k < 15) chk("clear_busy", ready0, 0);
      if (k == 15) chk("clear_done", ready0, 1);
    end
    idle();

    // Garbage, then a one-cycle reset and a full re-clear.
    for (int k = 0; k < 16; k++) wr_a(4'(k), 16'($urandom) | 16'h1);
    idle(); rst = 1'b1; cyc(); rst = 1'b0;
    for (int k = 0; k < 16; k++) cyc();
    chk("reclear_ready", ready0, 1);
    for (int k = 0; k < 16; k++) begin
      rd(4'(k));
      chk("clear_zero", rdata0, 0);
    end

    // Load then back-to-back reads.
    a_en = 1'b0; ld_valid = 1'b1; ld_addr = 4'hA; ld_data = 16'h1234; cyc();
    ld_addr = 4'hB; ld_data = 16'hBEEF; cyc();
    rd(4'hA);
    chk("ld_rd_a", rdata0, 16'h1234);
    chk("ld_rv_a", rvalid0, 1);
    rd(4'hB);
    chk("ld_rd_b", rdata0, 16'hBEEF);
    chk("ld_rv_b", rvalid0, 1);
    idle(); cyc();

    // Port A write blocks a concurrent load for one cycle.
    a_en = 1'b1; a_wen = 1'b1; a_addr = 4'h5; a_wdata = 16'h1111;
    ld_valid = 1'b1; ld_addr = 4'h6; ld_data = 16'h2222;
    #1 chk("conflict_ldrdy", ldrdy0, 0);
    cyc();
    a_en = 1'b0;
    #1 chk("conflict_ldrdy_next", ldrdy0, 1);
    cyc();
    rd(4'h5); chk("conflict_m5", rdata0, 16'h1111);
    rd(4'h6); chk("conflict_m6", rdata0, 16'h2222);

    // Read-during-write from the load port.
    wr_a(4'h3, 16'h00AA);
    a_en = 1'b1; a_wen = 1'b0; a_addr = 4'h3;
    ld_valid = 1'b1; ld_addr = 4'h3; ld_data = 16'h00BB;
    cyc();
    chk("rdw_old", rdata0, 16'h00AA);
    chk("rdw_new", rdata1, 16'h00BB);
    rd(4'h3);
    chk("rdw_after", rdata0, 16'h00BB);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      a_en = 1'($urandom); a_wen = 1'($urandom);
      a_addr = 4'($urandom); a_wdata = 16'($urandom);
      ld_valid = 1'($urandom); ld_addr = 4'($urandom); ld_data = 16'($urandom);
      cyc();
    end
    idle();

    // Reset seven cycles into a clear; a read issued during the clear is dropped.
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin a_en = 1'b1; a_wen = 1'b0; a_addr = 4'h2; end
      else a_en = 1'b0;
      cyc();
      if (k == 3) chk("clear_rd_dropped", rvalid0, 0);
    end
    idle(); rst = 1'b1; cyc(); rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (k < 15) chk("midclr_busy", ready0, 0);
      else        chk("midclr_done", ready0, 1);
    end

    // No-clear instance keeps contents across reset.
    wr_a(4'h1, 16'h5A5A);
    idle(); rst2 = 1'b1; cyc();
    chk("noclr_rst_ready", ready2, 0);
    rst2 = 1'b0; cyc();
    chk("noclr_ready", ready2, 1);
    rd(4'h1);
    chk("noclr_keep", rdata2, 16'h5A5A);
    idle(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
